// File: rtl/tm_sample_sequencer.sv
// Front-end sequencer for the two-class Tsetlin-machine inference block:
// loads the clause exclude masks, registers samples, and collects the class result.
module tm_sample_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [1:0] s_features,
    output logic [1:0] features,
    output logic [3:0] exclude_state1,
    output logic [3:0] exclude_state2,
    output logic [3:0] exclude_state3,
    output logic [3:0] exclude_state4,
    output logic [3:0] exclude_state5,
    output logic [3:0] exclude_state6,
    output logic [3:0] exclude_state7,
    output logic [3:0] exclude_state8,
    input  logic [1:0] class_in,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] m_class,
    output logic       model_loaded,
    output logic [7:0] result_count
);

    localparam logic [2:0] EMPTY = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] IDLE  = 3'd2;
    localparam logic [2:0] EVAL  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    logic [2:0]      state;
    logic [2:0]      load_cnt;
    logic [3:0]      settle_cnt;
    logic [7:0][3:0] mask;

    assign exclude_state1 = mask[0];
    assign exclude_state2 = mask[1];
    assign exclude_state3 = mask[2];
    assign exclude_state4 = mask[3];
    assign exclude_state5 = mask[4];
    assign exclude_state6 = mask[5];
    assign exclude_state7 = mask[6];
    assign exclude_state8 = mask[7];

    // s_ready is kept as its own flop, set on every transition into IDLE,
    // so the port is driven straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            load_cnt     <= 3'd0;
            settle_cnt   <= 4'd0;
            mask         <= '0;
            features     <= 2'b00;
            s_ready      <= 1'b0;
            m_valid      <= 1'b0;
            m_class      <= 2'b00;
            model_loaded <= 1'b0;
            result_count <= 8'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (cfg_start) begin
                        state    <= LOAD;
                        load_cnt <= 3'd0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        // restart; a nibble presented with the restart is the first one
                        if (cfg_valid) begin
                            mask[0]  <= cfg_data;
                            load_cnt <= 3'd1;
                        end else begin
                            load_cnt <= 3'd0;
                        end
                    end else if (cfg_valid) begin
                        mask[load_cnt] <= cfg_data;
                        if (load_cnt == 3'd7) begin
                            load_cnt     <= 3'd0;
                            model_loaded <= 1'b1;
                            s_ready      <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            load_cnt <= load_cnt + 3'd1;
                        end
                    end
                end
                IDLE: begin
                    if (cfg_start) begin
                        model_loaded <= 1'b0;
                        s_ready      <= 1'b0;
                        load_cnt     <= 3'd0;
                        state        <= LOAD;
                    end else if (s_valid) begin
                        features   <= s_features;
                        settle_cnt <= SETTLE_INIT;
                        s_ready    <= 1'b0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    if (settle_cnt == 4'd0) begin
                        m_class <= class_in;
                        m_valid <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid      <= 1'b0;
                        result_count <= result_count + 8'd1;
                        s_ready      <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    s_ready <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm_sample_sequencer.sv
// Directed bench for tm_sample_sequencer; two instances (SETTLE_CYCLES=1 and 3)
// share all inputs so latency differences can be compared side by side.
module tb_tm_sample_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_data = 4'h0;
    logic       s_valid = 1'b0;
    logic [1:0] s_features = 2'b00;
    logic [1:0] class_in = 2'b00;
    logic       m_ready = 1'b0;

    logic            a_s_ready, b_s_ready;
    logic [1:0]      a_features, b_features;
    logic [7:0][3:0] a_ex, b_ex;
    logic            a_m_valid, b_m_valid;
    logic [1:0]      a_m_class, b_m_class;
    logic            a_loaded, b_loaded;
    logic [7:0]      a_count, b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tm_sample_sequencer #(.SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_features(s_features), .features(a_features),
        .exclude_state1(a_ex[0]), .exclude_state2(a_ex[1]), .exclude_state3(a_ex[2]),
        .exclude_state4(a_ex[3]), .exclude_state5(a_ex[4]), .exclude_state6(a_ex[5]),
        .exclude_state7(a_ex[6]), .exclude_state8(a_ex[7]),
        .class_in(class_in), .m_valid(a_m_valid), .m_ready(m_ready),
        .m_class(a_m_class), .model_loaded(a_loaded), .result_count(a_count)
    );

    tm_sample_sequencer #(.SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_features(s_features), .features(b_features),
        .exclude_state1(b_ex[0]), .exclude_state2(b_ex[1]), .exclude_state3(b_ex[2]),
        .exclude_state4(b_ex[3]), .exclude_state5(b_ex[4]), .exclude_state6(b_ex[5]),
        .exclude_state7(b_ex[6]), .exclude_state8(b_ex[7]),
        .class_in(class_in), .m_valid(b_m_valid), .m_ready(m_ready),
        .m_class(b_m_class), .model_loaded(b_loaded), .result_count(b_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_model();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cfg_data = 4'(k + 1);
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({a_s_ready, a_m_valid, a_m_class, a_features, a_loaded, a_count, a_ex} !== '0) begin
            errors++;
            $display("FAIL reset_a: got rdy=%b mv=%b cls=%b f=%b ld=%b cnt=%0d ex=%h, want all zero",
                     a_s_ready, a_m_valid, a_m_class, a_features, a_loaded, a_count, a_ex);
        end
        checks++;
        if ({b_s_ready, b_m_valid, b_m_class, b_features, b_loaded, b_count, b_ex} !== '0) begin
            errors++;
            $display("FAIL reset_b: got nonzero outputs ex=%h cnt=%0d", b_ex, b_count);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sample_before_load();
        s_valid    = 1'b1;
        s_features = 2'b10;
        repeat (3) begin
            step();
            checks++;
            if (a_s_ready !== 1'b0 || a_features !== 2'b00 || a_m_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_sample: rdy=%b f=%b mv=%b, want 0 00 0",
                         a_s_ready, a_features, a_m_valid);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_load();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cfg_data = 4'(k + 1);
            step();
            if (k < 7) begin
                checks++;
                if (a_loaded !== 1'b0 || a_s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL load_early: write %0d ld=%b rdy=%b, want 0 0", k, a_loaded, a_s_ready);
                end
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (a_loaded !== 1'b1 || b_loaded !== 1'b1 || a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done: ld=%b/%b rdy=%b/%b, want 1", a_loaded, b_loaded, a_s_ready, b_s_ready);
        end
        checks++;
        if (a_ex !== 32'h8765_4321 || b_ex !== 32'h8765_4321) begin
            errors++;
            $display("FAIL load_masks: got %h/%h, want 87654321", a_ex, b_ex);
        end
    endtask

    task automatic test_latency();
        s_valid    = 1'b1;
        s_features = 2'b01;
        class_in   = 2'b10;
        step();  // acceptance edge E0
        s_valid = 1'b0;
        checks++;
        if (a_features !== 2'b01 || b_features !== 2'b01 || a_m_valid !== 1'b0 || a_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept: f=%b/%b mv=%b rdy=%b, want 01/01 0 0", a_features, b_features, a_m_valid, a_s_ready);
        end
        step();  // E1
        checks++;
        if (a_m_valid !== 1'b1 || a_m_class !== 2'b10 || b_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat1: a mv=%b cls=%b b mv=%b, want 1 10 0", a_m_valid, a_m_class, b_m_valid);
        end
        step();  // E2
        checks++;
        if (b_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat3_early: b mv=%b at E2, want 0", b_m_valid);
        end
        step();  // E3
        checks++;
        if (b_m_valid !== 1'b1 || b_m_class !== 2'b10) begin
            errors++;
            $display("FAIL lat3: b mv=%b cls=%b at E3, want 1 10", b_m_valid, b_m_class);
        end
        class_in = 2'b01;
        step();
        checks++;
        if (a_m_class !== 2'b10 || b_m_class !== 2'b10) begin
            errors++;
            $display("FAIL class_hold: cls=%b/%b after class_in change, want 10", a_m_class, b_m_class);
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (a_m_valid !== 1'b1 || a_m_class !== 2'b10 || a_features !== 2'b01 || a_s_ready !== 1'b0 ||
                b_m_valid !== 1'b1 || b_s_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure: cyc %0d mv=%b cls=%b f=%b rdy=%b b mv=%b rdy=%b",
                         i, a_m_valid, a_m_class, a_features, a_s_ready, b_m_valid, b_s_ready);
            end
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++;
        if (a_m_valid !== 1'b0 || a_count !== 8'd1 || a_s_ready !== 1'b1 || b_count !== 8'd1 || b_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake: mv=%b cnt=%0d/%0d rdy=%b/%b, want 0 1/1 1/1",
                     a_m_valid, a_count, b_count, a_s_ready, b_s_ready);
        end
    endtask

    task automatic test_restart();
        cfg_start = 1'b1;
        s_valid   = 1'b1;
        step();
        cfg_start = 1'b0;
        s_valid   = 1'b0;
        checks++;
        if (a_loaded !== 1'b0 || a_s_ready !== 1'b0 || a_features !== 2'b01) begin
            errors++;
            $display("FAIL reload_start: ld=%b rdy=%b f=%b, want 0 0 01", a_loaded, a_s_ready, a_features);
        end
        cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cfg_data = 4'h1;
            step();
        end
        cfg_start = 1'b1;
        cfg_data  = 4'hA;
        step();
        cfg_start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            cfg_data = 4'(15 - i);
            step();
            if (i < 7) begin
                checks++;
                if (a_loaded !== 1'b0) begin
                    errors++;
                    $display("FAIL restart_early: write %0d ld=%b, want 0", i, a_loaded);
                end
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (a_loaded !== 1'b1 || a_ex !== 32'h89AB_CDEA || b_ex !== 32'h89AB_CDEA) begin
            errors++;
            $display("FAIL restart_done: ld=%b ex=%h/%h, want 1 89abcdea", a_loaded, a_ex, b_ex);
        end
    endtask

    task automatic test_async_reset();
        s_valid    = 1'b1;
        s_features = 2'b11;
        step();
        s_valid = 1'b0;
        step();  // dut_b is mid-EVAL here
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b_s_ready, b_m_valid, b_m_class, b_features, b_loaded, b_count, b_ex} !== '0 ||
            {a_s_ready, a_m_valid, a_m_class, a_features, a_loaded, a_count, a_ex} !== '0) begin
            errors++;
            $display("FAIL async_reset: b mv=%b f=%b ld=%b cnt=%0d ex=%h a mv=%b, want all zero",
                     b_m_valid, b_features, b_loaded, b_count, b_ex, a_m_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (a_m_valid !== 1'b0 || b_m_valid !== 1'b0 || a_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: mv=%b/%b rdy=%b, want 0 0 0", a_m_valid, b_m_valid, a_s_ready);
        end
    endtask

    task automatic test_wrap();
        int guard;
        load_model();
        m_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            guard = 0;
            while (!(a_s_ready && b_s_ready) && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) begin
                checks++;
                errors++;
                $display("FAIL wrap_timeout: iteration %0d rdy=%b/%b", i, a_s_ready, b_s_ready);
                break;
            end
            if (i == 255) begin
                checks++;
                if (a_count !== 8'd255 || b_count !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255: cnt=%0d/%0d, want 255", a_count, b_count);
                end
            end
            if (i == 256) begin
                checks++;
                if (a_count !== 8'd0 || b_count !== 8'd0) begin
                    errors++;
                    $display("FAIL count_wrap: cnt=%0d/%0d, want 0", a_count, b_count);
                end
                break;
            end
            s_valid    = 1'b1;
            s_features = 2'(i);
            step();
            s_valid = 1'b0;
        end
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sample_before_load();
        test_load();
        test_latency();
        test_backpressure();
        test_restart();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
